// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, drives a synchronous instruction SRAM
// and offers {pc, inst} to ID through a valid/ready style handshake.
module if_fetch #(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ctl_jbr_taken_i,
  input  logic [W-1:0] jbr_target_i,
  input  logic         ctl_id_allow_in_i,
  output logic         inst_sram_en_o,
  output logic [W-1:0] inst_sram_addr_o,
  input  logic [W-1:0] inst_sram_rdata_i,
  output logic [W-1:0] if_pc_o,
  output logic [W-1:0] if_inst_o,
  output logic         ctl_if_over_o
);

  // Handshake: ctl_if_over_o is valid, ctl_id_allow_in_i is ready. A transfer
  // ("fire") happens when both are high and no redirect is reported; a redirect
  // always wins and drops the offered instruction without a transfer.

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] req_pc_q, req_pc_d;
  logic [W-1:0] hold_inst_q, hold_inst_d;

  logic [W-1:0] tgt_pc;
  logic [W-1:0] next_pc;
  logic         fire;

  assign tgt_pc  = {jbr_target_i[W-1:2], 2'b00};
  assign next_pc = req_pc_q + W'(4);

  always_comb begin
    state_d          = state_q;
    req_pc_d         = req_pc_q;
    hold_inst_d      = hold_inst_q;
    inst_sram_en_o   = 1'b0;
    inst_sram_addr_o = req_pc_q;
    if_pc_o          = req_pc_q;
    if_inst_o        = hold_inst_q;
    ctl_if_over_o    = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if_pc_o          = RESET_PC;
        if_inst_o        = '0;
        inst_sram_en_o   = 1'b1;
        inst_sram_addr_o = ctl_jbr_taken_i ? tgt_pc : RESET_PC;
        req_pc_d         = ctl_jbr_taken_i ? tgt_pc : RESET_PC;
        state_d          = ST_WAIT;
      end
      ST_WAIT: begin
        ctl_if_over_o = 1'b1;
        if_inst_o     = inst_sram_rdata_i;
        if (ctl_jbr_taken_i) begin
          inst_sram_en_o   = 1'b1;
          inst_sram_addr_o = tgt_pc;
          req_pc_d         = tgt_pc;
        end else if (ctl_id_allow_in_i) begin
          inst_sram_en_o   = 1'b1;
          inst_sram_addr_o = next_pc;
          req_pc_d         = next_pc;
        end else begin
          // SRAM data is only valid this one cycle, so park it for the stall.
          hold_inst_d = inst_sram_rdata_i;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        ctl_if_over_o = 1'b1;
        if (ctl_jbr_taken_i) begin
          inst_sram_en_o   = 1'b1;
          inst_sram_addr_o = tgt_pc;
          req_pc_d         = tgt_pc;
          state_d          = ST_WAIT;
        end else if (ctl_id_allow_in_i) begin
          inst_sram_en_o   = 1'b1;
          inst_sram_addr_o = next_pc;
          req_pc_d         = next_pc;
          state_d          = ST_WAIT;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // While reset is held the stage looks exactly like a fresh BOOT with no request.
    if (rst_i) begin
      inst_sram_en_o   = 1'b0;
      inst_sram_addr_o = RESET_PC;
      if_pc_o          = RESET_PC;
      if_inst_o        = '0;
      ctl_if_over_o    = 1'b0;
    end
  end

  assign fire = ctl_if_over_o & ctl_id_allow_in_i & ~ctl_jbr_taken_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_BOOT;
      req_pc_q    <= RESET_PC;
      hold_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  a_addr_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    inst_sram_addr_o[1:0] == 2'b00);

  a_offer_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (ctl_if_over_o && !fire && !ctl_jbr_taken_i)
      |=> ($stable(if_pc_o) && $stable(if_inst_o) && ctl_if_over_o));

  a_no_read_in_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ST_HOLD && !ctl_jbr_taken_i && !ctl_id_allow_in_i) |-> !inst_sram_en_o);

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle-by-cycle vector table through stream, stall,
// redirect and wrap, then a reset-during-HOLD sequence, with a transfer scoreboard.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ctl_jbr_taken_i;
  logic [31:0] jbr_target_i;
  logic        ctl_id_allow_in_i;
  logic        inst_sram_en_o;
  logic [31:0] inst_sram_addr_o;
  logic [31:0] inst_sram_rdata_i = 32'h0;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        ctl_if_over_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  if_fetch #(.W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .ctl_jbr_taken_i   (ctl_jbr_taken_i),
    .jbr_target_i      (jbr_target_i),
    .ctl_id_allow_in_i (ctl_id_allow_in_i),
    .inst_sram_en_o    (inst_sram_en_o),
    .inst_sram_addr_o  (inst_sram_addr_o),
    .inst_sram_rdata_i (inst_sram_rdata_i),
    .if_pc_o           (if_pc_o),
    .if_inst_o         (if_inst_o),
    .ctl_if_over_o     (ctl_if_over_o)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // synchronous SRAM: data for the previous cycle's request
  always @(posedge clk) begin
    if (inst_sram_en_o) inst_sram_rdata_i <= mem_f(inst_sram_addr_o);
  end

  typedef struct {
    logic        jbr;
    logic [31:0] tgt;
    logic        allow;
    logic        exp_over;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic jbr, input logic [31:0] tgt, input logic allow,
                              input logic over, input logic en, input logic [31:0] addr,
                              input logic [31:0] pc);
    vec_t v;
    v.jbr = jbr; v.tgt = tgt; v.allow = allow;
    v.exp_over = over; v.exp_en = en; v.exp_addr = addr; v.exp_pc = pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard: pop one expected pc per observed transfer
  task automatic sb_sample();
    logic [31:0] e;
    if (ctl_if_over_o && ctl_id_allow_in_i && !ctl_jbr_taken_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc %h expected no transfer", if_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", if_pc_o, e);
        chk("sb_inst", if_inst_o, mem_f(e));
      end
    end
  endtask

  // driver: one cycle of inputs, then check combinational outputs
  task automatic drive(input logic rst, input logic jbr, input logic [31:0] tgt, input logic allow);
    @(negedge clk);
    rst_i             = rst;
    ctl_jbr_taken_i   = jbr;
    jbr_target_i      = tgt;
    ctl_id_allow_in_i = allow;
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic over, input logic en,
                             input logic [31:0] addr, input logic [31:0] pc);
    chk({tag, "_over"}, {31'b0, ctl_if_over_o}, {31'b0, over});
    chk({tag, "_en"}, {31'b0, inst_sram_en_o}, {31'b0, en});
    if (en) chk({tag, "_addr"}, inst_sram_addr_o, addr);
    chk({tag, "_pc"}, if_pc_o, pc);
    chk({tag, "_inst"}, if_inst_o, over ? mem_f(pc) : 32'h0);
    sb_sample();
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000);
    tbl[1]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000);
    tbl[2]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0004);
    tbl[3]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0008);
    tbl[4]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0008);
    tbl[5]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0008);
    tbl[6]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_000C, 32'h0000_0008);
    tbl[7]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_000C);
    tbl[8]  = mk(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0010);
    tbl[9]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_0100);
    tbl[10] = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0104);
    tbl[11] = mk(1'b1, 32'h0000_0203, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0104);
    tbl[12] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0204, 32'h0000_0200);
    tbl[13] = mk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0204);
    tbl[14] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC);
    tbl[15] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000);

    // transfers the table is expected to produce, in order
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_0008);
    exp_q.push_back(32'h0000_000C);
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);

    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    check_cycle("reset", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("reset_addr", inst_sram_addr_o, 32'h0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, tbl[i].jbr, tbl[i].tgt, tbl[i].allow);
      check_cycle($sformatf("row%0d", i), tbl[i].exp_over, tbl[i].exp_en,
                  tbl[i].exp_addr, tbl[i].exp_pc);
    end

    // stall into HOLD, then reset while holding
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check_cycle("pre_hold", 1'b1, 1'b0, 32'h0, 32'h0000_0004);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check_cycle("hold", 1'b1, 1'b0, 32'h0, 32'h0000_0004);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    check_cycle("rst_in_hold", 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    check_cycle("rst_held", 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check_cycle("reboot", 1'b0, 1'b1, 32'h0, 32'h0);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check_cycle("restart0", 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check_cycle("restart1", 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0004);

    chk("sb_drained", exp_q.size(), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
